// File: rtl/x_input_conditioner_pkg.sv
// Shared definitions for the X input conditioner: debounce state encodings
// and the glitch counter ceiling.
package x_input_conditioner_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'b00,
        RISE_PEND   = 2'b01,
        HIGH_STABLE = 2'b11,
        FALL_PEND   = 2'b10
    } state_t;

    localparam logic [7:0] GLITCH_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; the output is only
// safe to use after the second stage.
module sync_2ff (
    input  logic CLOCK,
    input  logic RESET,
    input  logic async_in,
    output logic sync_out
);

    logic stage1_reg;
    logic stage2_reg;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            stage1_reg <= 1'b0;
            stage2_reg <= 1'b0;
        end else begin
            stage1_reg <= async_in;
            stage2_reg <= stage1_reg;
        end
    end

    assign sync_out = stage2_reg;

endmodule

// File: rtl/x_input_conditioner.sv
// Synchronises and debounces the raw X input, producing a clean registered
// level, one-cycle edge pulses and a saturating count of rejected bounces.
module x_input_conditioner
    import x_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 4,
    parameter int CNT_WIDTH      = 3
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       RAW_IN,
    output logic       X,
    output logic       X_RISE,
    output logic       X_FALL,
    output logic [7:0] GLITCH_CNT,
    output logic [1:0] STATE
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

    logic                 sync_level;
    state_t               state_reg;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 x_next;
    logic                 rise_next;
    logic                 fall_next;
    logic                 abort;
    logic [7:0]           glitch_next;

    sync_2ff u_sync (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .async_in (RAW_IN),
        .sync_out (sync_level)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_reg  <= LOW_STABLE;
            cnt_reg    <= '0;
            X          <= 1'b0;
            X_RISE     <= 1'b0;
            X_FALL     <= 1'b0;
            GLITCH_CNT <= 8'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            X          <= x_next;
            X_RISE     <= rise_next;
            X_FALL     <= fall_next;
            GLITCH_CNT <= glitch_next;
        end
    end

    // The counter is zeroed on every entry to and exit from a pending state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            LOW_STABLE: begin
                if (sync_level) begin
                    state_next = RISE_PEND;
                    cnt_next   = '0;
                end
            end
            RISE_PEND: begin
                if (!sync_level) begin
                    state_next = LOW_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = HIGH_STABLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HIGH_STABLE: begin
                if (!sync_level) begin
                    state_next = FALL_PEND;
                    cnt_next   = '0;
                end
            end
            FALL_PEND: begin
                if (sync_level) begin
                    state_next = HIGH_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = LOW_STABLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = LOW_STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        x_next    = X;
        rise_next = 1'b0;
        fall_next = 1'b0;
        abort     = 1'b0;
        case (state_reg)
            RISE_PEND: begin
                if (!sync_level) begin
                    abort = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    x_next    = 1'b1;
                    rise_next = 1'b1;
                end
            end
            FALL_PEND: begin
                if (sync_level) begin
                    abort = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    x_next    = 1'b0;
                    fall_next = 1'b1;
                end
            end
            default: ;
        endcase
        glitch_next = (abort && (GLITCH_CNT != GLITCH_MAX)) ? GLITCH_CNT + 8'd1 : GLITCH_CNT;
    end

    assign STATE = state_reg;

endmodule

// File: doc/x_input_conditioner.md
Name: x_input_conditioner

Overview:
- Front-end conditioner for the single-bit serial input X of the sequence-detector FSM.
- Takes an asynchronous, bouncy RAW_IN (switch or pin) and synchronises it to CLOCK, then debounces it with a four-state FSM.
- Drives a clean registered level X into the downstream FSM, plus one-cycle edge pulses and a saturating glitch counter for debug.

Parameters:
- DEBOUNCE_COUNT, 4, number of consecutive stable synchronised samples (after pending entry) needed to accept a level change; must be >= 1.
- CNT_WIDTH, 3, width of the debounce counter; 2^CNT_WIDTH >= DEBOUNCE_COUNT required.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- RAW_IN  input  1  asynchronous raw input.
- X  output  1  debounced level (registered), feeds the downstream FSM X input.
- X_RISE  output  1  one-cycle pulse, coincident with the cycle X first reads 1.
- X_FALL  output  1  one-cycle pulse, coincident with the cycle X first reads 0.
- GLITCH_CNT  output  8  saturating count of aborted pending transitions.
- STATE  output  2  current debounce state, for debug.

Behaviour:
- One clock (CLOCK); reset is asynchronous and active-high (RESET). All flops clear immediately on RESET without a clock edge.
- Reset values: sync1=0, sync2=0, STATE=LOW_STABLE, counter=0, X=0, X_RISE=0, X_FALL=0, GLITCH_CNT=0.
- Synchroniser: two flops, RAW_IN -> sync1 -> sync2. The FSM sees only sync2.
- States: LOW_STABLE=2'b00, RISE_PEND=2'b01, HIGH_STABLE=2'b11, FALL_PEND=2'b10.
- LOW_STABLE:
  - sync2=1 -> RISE_PEND, counter<=0.
  - Otherwise hold.
- RISE_PEND:
  - sync2=0 -> LOW_STABLE, counter<=0, GLITCH_CNT+1 (saturate at 255).
  - Else if counter==DEBOUNCE_COUNT-1 -> HIGH_STABLE, X<=1, X_RISE<=1.
  - Else counter<=counter+1.
- HIGH_STABLE: mirror of LOW_STABLE (sync2=0 -> FALL_PEND, counter<=0).
- FALL_PEND: mirror of RISE_PEND:
  - sync2=1 -> HIGH_STABLE, counter<=0, GLITCH_CNT+1.
  - Counter at terminal value -> LOW_STABLE, X<=0, X_FALL<=1.
- X_RISE and X_FALL default to 0 every cycle. They are never both 1, and each is high for exactly one cycle per accepted edge.
- X changes only on a state transition into a *_STABLE state from the matching *_PEND state.
- Latency: let edge 0 be the first rising edge that samples RAW_IN=1 (held steady). X and X_RISE become 1 after edge DEBOUNCE_COUNT+2, i.e. the (DEBOUNCE_COUNT+3)th edge. Falling edges have the same latency.
- Pulse acceptance: a RAW_IN pulse of L cycles is accepted iff L >= DEBOUNCE_COUNT+1. Any shorter pulse, including L=1, is rejected and counts exactly one glitch.
- Counter never wraps; it only counts inside *_PEND states and is cleared on every *_PEND entry and exit.
- GLITCH_CNT saturates at 8'hFF. It holds at 255 on further glitches and is cleared only by RESET.
- Reset mid-operation (any state, including *_PEND): immediate return to reset values. The next transition requires the full latency.
- No combinational path from RAW_IN to any output; all outputs are registered.

Decomposition:
- Shared package: state encodings LOW_STABLE/RISE_PEND/HIGH_STABLE/FALL_PEND as 2-bit constants, and GLITCH_MAX=8'hFF.
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with CLOCK and async active-high RESET. It is reused for any future asynchronous input.
- Debounce FSM, counter, pulse and glitch logic live in x_input_conditioner.

Test Plan (DEBOUNCE_COUNT=4):
- Async reset: with X=1 and GLITCH_CNT=5, assert RESET between clock edges -> X=0, STATE=00, GLITCH_CNT=0, X_RISE=X_FALL=0 before the next edge.
- Clean rise: RAW_IN 0->1 held 20 cycles -> X=1 after edge 6 (7th edge), X_RISE=1 for exactly that one cycle, STATE=11, GLITCH_CNT=0.
- Bounce rejection: RAW_IN high for 4 cycles then low -> X stays 0, STATE returns to 00, GLITCH_CNT=1. A 5-cycle high pulse -> X=1 with one X_RISE.
- Clean fall: from HIGH_STABLE, RAW_IN 1->0 held -> X=0 after 7th edge, X_FALL one cycle, X_RISE stays 0.
- Saturation: 300 one-cycle RAW_IN pulses spaced 10 cycles apart -> GLITCH_CNT=255, X=0 throughout.
- Reset mid-pending: RAW_IN high 3 cycles (STATE=01), pulse RESET, keep RAW_IN high -> X=1 only on the 7th edge after RESET release, with exactly one X_RISE.
